// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop slot register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_hwloop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        ARMED = 2'd2
    } hwlp_slot_state_e;

    // Bit positions inside the 3-bit write-enable / config-mask vectors.
    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

endpackage

// File: rtl/riscv_hwloop_slot.sv
// One hardware-loop slot: start/end/count fields, config mask, arming FSM, optional total (RISCV_HWLOOP_ITER_TOTAL_EN).
// Latency: writes and decrements land on the next clk edge; outputs come straight from registers.
// Backpressure: none; dec_i is already arbitrated by the parent, a count write in the same cycle suppresses it.
module riscv_hwloop_slot
    import riscv_hwloop_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setback_i,
    input  logic [2:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] start_data_i,
    input  logic [ADDR_WIDTH-1:0] end_data_i,
    input  logic [CNT_WIDTH-1:0]  cnt_data_i,
    input  logic                  dec_i,
    output logic [ADDR_WIDTH-1:0] start_addr_o,
    output logic [ADDR_WIDTH-1:0] end_addr_o,
    output logic [CNT_WIDTH-1:0]  counter_o,
    output logic                  active_o,
    output logic                  last_iter_o,
    output logic [31:0]           iter_total_o
);

    hwlp_slot_state_e      state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]            mask_q, mask_d;
    logic                  dec_apply;
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
    logic [31:0]           total_q, total_d;
`endif

    // Next-state: field writes, saturating decrement, mask tracking and arming FSM.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
        total_d = total_q;
`endif
        // A count write to this slot always wins over its decrement.
        dec_apply = dec_i && (state_q == ARMED) && !we_i[HWLP_WE_CNT];

        if (we_i[HWLP_WE_START]) start_d = start_data_i;
        if (we_i[HWLP_WE_END])   end_d   = end_data_i;
        if (we_i[HWLP_WE_CNT]) begin
            cnt_d = cnt_data_i;
        end else if (dec_apply && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
        if (dec_apply) total_d = total_q + 32'd1;
`endif
        mask_d = mask_q | we_i;

        unique case (state_q)
            IDLE: begin
                if (|we_i) state_d = CFG;
            end
            CFG: begin
                // Arming looks at post-write values so the final write arms on the same edge.
                if ((mask_d == 3'b111) && (cnt_d != '0)) state_d = ARMED;
            end
            ARMED: begin
                // Either the last iteration retired or a zero count was written.
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    mask_d  = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = 3'b000;
            end
        endcase

        if (setback_i) begin
            state_d = IDLE;
            start_d = '0;
            end_d   = '0;
            cnt_d   = '0;
            mask_d  = 3'b000;
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
            total_d = 32'd0;
`endif
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= 3'b000;
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
            total_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
            total_q <= total_d;
`endif
        end
    end

    assign start_addr_o = start_q;
    assign end_addr_o   = end_q;
    assign counter_o    = cnt_q;
    assign active_o     = (state_q == ARMED);
    assign last_iter_o  = (state_q == ARMED) && (cnt_q == CNT_WIDTH'(1));
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
    assign iter_total_o = total_q;
`else
    assign iter_total_o = 32'd0;
`endif

endmodule

// File: rtl/riscv_hwloop_slot_regs.sv
// Hardware-loop register file: write decode, lowest-index decrement arbitration, sticky multi-decrement error (optional totals: RISCV_HWLOOP_ITER_TOTAL_EN).
// Latency: 1 cycle from write/decrement to register outputs; last_iter is combinational from registers.
// Backpressure: none; extra simultaneous decrements are dropped and flagged on multi_dec_err_o.
module riscv_hwloop_slot_regs
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         setback_i,
    input  logic [ADDR_WIDTH-1:0]        hwlp_start_data_i,
    input  logic [ADDR_WIDTH-1:0]        hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0]         hwlp_cnt_data_i,
    input  logic [2:0]                   hwlp_we_i,
    input  logic [N_REG_BITS-1:0]        hwlp_regid_i,
    input  logic                         valid_i,
    input  logic [N_REGS-1:0]            hwlp_dec_cnt_i,
    input  logic                         err_clr_i,
    output logic [N_REGS*ADDR_WIDTH-1:0] hwlp_start_addr_o,
    output logic [N_REGS*ADDR_WIDTH-1:0] hwlp_end_addr_o,
    output logic [N_REGS*CNT_WIDTH-1:0]  hwlp_counter_o,
    output logic [N_REGS-1:0]            hwlp_active_o,
    output logic [N_REGS-1:0]            hwlp_last_iter_o,
    output logic                         multi_dec_err_o,
    output logic [N_REGS*32-1:0]         iter_total_o
);

    logic [2:0]        slot_we [N_REGS];
    logic [N_REGS-1:0] dec_grant;
    logic              grant_found;
    logic              err_q, err_d;

    // Route the write enables to the addressed slot; out-of-range ids match nothing.
    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            slot_we[k] = (int'(hwlp_regid_i) == k) ? hwlp_we_i : 3'b000;
        end
    end

    // Grant the decrement to the lowest-index requesting slot that is armed.
    always_comb begin
        dec_grant   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < N_REGS; k++) begin
            if (!grant_found && valid_i && hwlp_dec_cnt_i[k] && hwlp_active_o[k]) begin
                dec_grant[k] = 1'b1;
                grant_found  = 1'b1;
            end
        end
    end

    // Sticky error: a new multi-decrement beats a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (setback_i) begin
            err_d = 1'b0;
        end else if (valid_i && ($countones(hwlp_dec_cnt_i) > 1)) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign multi_dec_err_o = err_q;

    for (genvar g = 0; g < N_REGS; g++) begin : g_slot
        riscv_hwloop_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .setback_i    (setback_i),
            .we_i         (slot_we[g]),
            .start_data_i (hwlp_start_data_i),
            .end_data_i   (hwlp_end_data_i),
            .cnt_data_i   (hwlp_cnt_data_i),
            .dec_i        (dec_grant[g]),
            .start_addr_o (hwlp_start_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .end_addr_o   (hwlp_end_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .counter_o    (hwlp_counter_o[g*CNT_WIDTH +: CNT_WIDTH]),
            .active_o     (hwlp_active_o[g]),
            .last_iter_o  (hwlp_last_iter_o[g]),
            .iter_total_o (iter_total_o[g*32 +: 32])
        );
    end

endmodule

// File: tb/tb_riscv_hwloop_slot_regs.sv
module tb_riscv_hwloop_slot_regs;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          setback_i = 1'b0;
    logic [31:0]   start_data = '0;
    logic [31:0]   end_data = '0;
    logic [31:0]   cnt_data = '0;
    logic [2:0]    we = '0;
    logic [0:0]    regid = '0;
    logic          valid = 1'b0;
    logic [N-1:0]  dec = '0;
    logic          err_clr = 1'b0;
    logic [N*32-1:0] start_o, end_o, cnt_o, tot_o;
    logic [N-1:0]  active_o, last_o;
    logic          err_o;

    riscv_hwloop_slot_regs #(.N_REGS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .setback_i         (setback_i),
        .hwlp_start_data_i (start_data),
        .hwlp_end_data_i   (end_data),
        .hwlp_cnt_data_i   (cnt_data),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .valid_i           (valid),
        .hwlp_dec_cnt_i    (dec),
        .err_clr_i         (err_clr),
        .hwlp_start_addr_o (start_o),
        .hwlp_end_addr_o   (end_o),
        .hwlp_counter_o    (cnt_o),
        .hwlp_active_o     (active_o),
        .hwlp_last_iter_o  (last_o),
        .multi_dec_err_o   (err_o),
        .iter_total_o      (tot_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: loop slots as plain records, stepped once per clock edge.
    logic [31:0] m_start [N];
    logic [31:0] m_end   [N];
    logic [31:0] m_cnt   [N];
    logic [31:0] m_tot   [N];
    bit   [2:0]  m_written [N];
    bit          m_armed [N];
    bit          m_cfg   [N];
    bit          m_err;

    always @(posedge clk or posedge rst) begin
        if (rst || setback_i) begin
            for (int k = 0; k < N; k++) begin
                m_start[k] = 0; m_end[k] = 0; m_cnt[k] = 0; m_tot[k] = 0;
                m_written[k] = 0; m_armed[k] = 0; m_cfg[k] = 0;
            end
            m_err = 0;
        end else begin
            int winner;
            winner = -1;
            for (int k = 0; k < N; k++)
                if (winner < 0 && valid && dec[k] && m_armed[k]) winner = k;
            if (valid && $countones(dec) > 1) m_err = 1;
            else if (err_clr) m_err = 0;
            for (int k = 0; k < N; k++) begin
                bit [2:0] w;
                bit       taken;
                w = (int'(regid) == k) ? we : 3'b000;
                taken = (winner == k) && !w[2];
                if (w[0]) m_start[k] = start_data;
                if (w[1]) m_end[k] = end_data;
                if (w[2]) m_cnt[k] = cnt_data;
                else if (taken && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                if (taken) m_tot[k] = m_tot[k] + 1;
                m_written[k] = m_written[k] | w;
                if (m_armed[k]) begin
                    if (m_cnt[k] == 0) begin
                        m_armed[k] = 0; m_written[k] = 0;
                    end
                end else if (m_cfg[k]) begin
                    if (m_written[k] == 3'b111 && m_cnt[k] != 0) begin
                        m_armed[k] = 1; m_cfg[k] = 0;
                    end
                end else if (w != 0) begin
                    m_cfg[k] = 1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge after reset.
    always @(negedge clk) begin
        if (started && !rst) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("start%0d", k), start_o[k*32 +: 32], m_start[k]);
                chk($sformatf("end%0d", k), end_o[k*32 +: 32], m_end[k]);
                chk($sformatf("cnt%0d", k), cnt_o[k*32 +: 32], m_cnt[k]);
                chk($sformatf("active%0d", k), 32'(active_o[k]), 32'(m_armed[k]));
                chk($sformatf("last%0d", k), 32'(last_o[k]), 32'(m_armed[k] && m_cnt[k] == 1));
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
                chk($sformatf("total%0d", k), tot_o[k*32 +: 32], m_tot[k]);
`else
                chk($sformatf("total%0d", k), tot_o[k*32 +: 32], 32'd0);
`endif
            end
            chk("err", 32'(err_o), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; valid = 0; dec = 0; err_clr = 0; setback_i = 0;
    endtask

    task automatic wr(input int slot, input logic [2:0] en, input logic [31:0] v);
        regid = 1'(slot); we = en;
        start_data = v; end_data = v; cnt_data = v;
        tick();
        idle_inputs();
    endtask

    task automatic pulse_dec(input logic [N-1:0] d, input logic clr);
        valid = 1; dec = d; err_clr = clr;
        tick();
        idle_inputs();
    endtask

    task automatic arm(input int slot, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        wr(slot, 3'b001, s);
        wr(slot, 3'b010, e);
        wr(slot, 3'b100, c);
    endtask

    initial begin
        #2 rst = 1;
        #20;
        chk("rst_cnt_o", cnt_o[31:0], 32'd0);
        chk("rst_active_o", 32'(active_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 0;
        started = 1;
        tick();

        // Configure slot 0 one field per cycle.
        wr(0, 3'b001, 32'h100);
        chk("cfg_start_active", 32'(active_o[0]), 32'd0);
        wr(0, 3'b010, 32'h120);
        chk("cfg_end_active", 32'(active_o[0]), 32'd0);
        chk("cfg_end_val", end_o[31:0], 32'h120);
        wr(0, 3'b100, 32'd3);
        chk("armed0", 32'(active_o[0]), 32'd1);
        chk("armed0_cnt", cnt_o[31:0], 32'd3);

        // Three decrements to exhaustion, then a saturated request.
        pulse_dec(2'b01, 0);
        chk("dec1_cnt", cnt_o[31:0], 32'd2);
        pulse_dec(2'b01, 0);
        chk("dec2_cnt", cnt_o[31:0], 32'd1);
        chk("dec2_last", 32'(last_o[0]), 32'd1);
        pulse_dec(2'b01, 0);
        chk("dec3_cnt", cnt_o[31:0], 32'd0);
        chk("dec3_active", 32'(active_o[0]), 32'd0);
        pulse_dec(2'b01, 0);
        chk("dec4_cnt", cnt_o[31:0], 32'd0);

        // Count write beats a same-cycle decrement.
        arm(1, 32'h200, 32'h240, 32'd5);
        chk("armed1", 32'(active_o[1]), 32'd1);
        regid = 1; we = 3'b100; cnt_data = 32'd9; valid = 1; dec = 2'b10;
        tick();
        idle_inputs();
        chk("wr_beats_dec", cnt_o[63:32], 32'd9);

        // Multiple decrement: only slot 0 moves, error is sticky.
        arm(0, 32'h300, 32'h340, 32'd4);
        pulse_dec(2'b11, 0);
        chk("multi_cnt0", cnt_o[31:0], 32'd3);
        chk("multi_cnt1", cnt_o[63:32], 32'd9);
        chk("multi_err", 32'(err_o), 32'd1);
        err_clr = 1;
        tick();
        idle_inputs();
        chk("err_cleared", 32'(err_o), 32'd0);
        pulse_dec(2'b11, 1);
        chk("set_beats_clr", 32'(err_o), 32'd1);
        err_clr = 1;
        tick();
        idle_inputs();

        // Zero count disarms; partial config with count 0 stays unarmed.
        wr(1, 3'b100, 32'd0);
        chk("zero_wr_disarm", 32'(active_o[1]), 32'd0);
        wr(1, 3'b001, 32'h400);
        wr(1, 3'b010, 32'h440);
        wr(1, 3'b100, 32'd0);
        chk("cfg_zero_active", 32'(active_o[1]), 32'd0);
        pulse_dec(2'b10, 0);
        chk("cfg_dec_ignored", cnt_o[63:32], 32'd0);
        wr(1, 3'b100, 32'd2);
        chk("cfg_rearm", 32'(active_o[1]), 32'd1);
        setback_i = 1; we = 3'b111; regid = 0; cnt_data = 32'd7; valid = 1; dec = 2'b01;
        tick();
        idle_inputs();
        chk("sb_start0", start_o[31:0], 32'd0);
        chk("sb_cnt0", cnt_o[31:0], 32'd0);
        chk("sb_active", 32'(active_o), 32'd0);

        // Iteration totals survive count rewrites and clear on setback.
        arm(0, 32'h500, 32'h540, 32'd10);
        for (int i = 0; i < 4; i++) pulse_dec(2'b01, 0);
        chk("tot_cnt", cnt_o[31:0], 32'd6);
`ifdef RISCV_HWLOOP_ITER_TOTAL_EN
        chk("tot4", tot_o[31:0], 32'd4);
        wr(0, 3'b100, 32'd7);
        chk("tot_keep", tot_o[31:0], 32'd4);
`else
        chk("tot_off", tot_o[31:0], 32'd0);
        wr(0, 3'b100, 32'd7);
`endif
        setback_i = 1;
        tick();
        idle_inputs();
        chk("tot_sb", tot_o[31:0], 32'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_slot_regs.md
Name: riscv_hwloop_slot_regs

Overview:
Parametrised next-generation hardware-loop register file for the RI5CY-family core. Holds start address, end address and iteration counter for N_REGS loops. Each loop slot has its own configuration/arming state machine, a saturating decrement, and last-iteration flags. Sits between the EX stage (register writes) and the hwloop controller (decrement requests, address/counter consumption); also flags protocol errors.

Parameters:
N_REGS, 2, number of hardware-loop slots (1..8)
N_REG_BITS, $clog2(N_REGS) (minimum 1), slot-select width
ADDR_WIDTH, 32, start/end address width
CNT_WIDTH, 32, iteration-counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
setback_i  in  1  synchronous clear of all slots and the error flag
hwlp_start_data_i  in  ADDR_WIDTH  start address write data
hwlp_end_data_i  in  ADDR_WIDTH  end address write data
hwlp_cnt_data_i  in  CNT_WIDTH  counter write data
hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] count
hwlp_regid_i  in  N_REG_BITS  target slot for writes
valid_i  in  1  instruction valid from controller; qualifies decrements
hwlp_dec_cnt_i  in  N_REGS  per-slot decrement request
err_clr_i  in  1  clears multi_dec_err_o
hwlp_start_addr_o  out  N_REGS*ADDR_WIDTH  start addresses
hwlp_end_addr_o  out  N_REGS*ADDR_WIDTH  end addresses
hwlp_counter_o  out  N_REGS*CNT_WIDTH  counters
hwlp_active_o  out  N_REGS  slot is in ARMED state
hwlp_last_iter_o  out  N_REGS  active and counter == 1 (combinational from registers)
multi_dec_err_o  out  1  sticky: more than one decrement in one valid cycle
iter_total_o  out  N_REGS*32  per-slot completed-decrement totals (optional feature)

Behaviour:
- Reset (rst high, asynchronous): all addresses, counters, masks and iter totals = 0; all slots IDLE; all outputs 0.
- setback_i (synchronous, highest priority after reset): same values as reset, applied on the next edge. Overrides same-cycle writes and decrements.
- Per-slot config mask (3 bits) records which fields have been written since the slot last left ARMED.
- Writes: when hwlp_we_i[b] is set, the selected field of slot hwlp_regid_i is written and mask bit b is set. Multiple enable bits may be set in the same cycle. Registers update on the next edge; latency is 1 cycle.
- FSM per slot, states IDLE, CFG, ARMED:
  - IDLE -> CFG on any write.
  - CFG -> ARMED when the post-write mask is 3'b111 and the post-write counter is != 0.
  - ARMED -> IDLE when the counter decrements from 1 to 0, or when a count write of 0 occurs; the mask clears on exit.
  - ARMED + non-zero count write: stays ARMED and loads the new count.
  - Start/end writes while ARMED update the fields in place; state is unchanged.
- Decrement:
  - Applies only when valid_i, hwlp_dec_cnt_i[k] and slot k is ARMED.
  - Counter saturates at 0; it never wraps.
  - A request to a slot that is not ARMED is ignored.
- Simultaneous events:
  - A count write to slot k beats a decrement of slot k (the write value is loaded and no decrement happens).
  - A write to slot j and a decrement of slot k != j both take effect.
- Multiple decrements: if valid_i and popcount(hwlp_dec_cnt_i) > 1, only the lowest-index requesting ARMED slot decrements, and multi_dec_err_o sets on the next edge.
  - The flag holds until err_clr_i, setback_i or rst.
  - A set condition in the same cycle as err_clr_i wins (flag stays 1).
- hwlp_last_iter_o[k] = ARMED && counter == 1.
- hwlp_regid_i >= N_REGS: write ignored.
- Data input widths equal the register widths; no truncation logic is required.

Optional Feature:
RISCV_HWLOOP_ITER_TOTAL_EN
- Defined: each slot has a 32-bit wrapping total that increments on every applied decrement. It is cleared only by rst or setback_i, not by count writes, and is driven on iter_total_o.
- Undefined: no total registers are built; iter_total_o is tied to 0.

Decomposition:
- Package riscv_hwloop_pkg holds:
  - hwlp_slot_state_e {IDLE, CFG, ARMED}
  - constants HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2
- Sub-module riscv_hwloop_slot holds one slot's fields, mask, FSM, decrement and optional total.
  - The top instantiates N_REGS copies.
  - The top also performs write decode, lowest-index decrement arbitration and the error flag.

Test Plan:
- Reset then write start=0x100, end=0x120, count=3 (one field per cycle) to slot 0 → active_o[0]=0 until the cycle after the count write, then 1; counter_o[0]=3.
- With slot 0 ARMED at count=3, pulse valid_i with dec[0] three times → counter 2, 1 (last_iter_o[0]=1), 0; active_o[0]=0 after the third pulse; a fourth dec leaves the counter at 0.
- Slot 1 ARMED at count=5; in the same cycle write count=9 to slot 1 and assert dec[1]&valid_i → counter_o[1]=9.
- Both slots ARMED; valid_i with dec=2'b11 → only slot 0 decrements and multi_dec_err_o=1; assert err_clr_i → flag 0 next cycle.
- Write only start and end to slot 1, then count=0 → slot stays in CFG and active_o[1]=0; then setback_i → all outputs 0.
- With RISCV_HWLOOP_ITER_TOTAL_EN defined: 4 applied decrements on slot 0 → iter_total_o[0]=4; a count rewrite keeps 4; setback_i → 0.
